// File: rtl/dac_multi_serializer.sv
// rtl/dac_multi_serializer.sv - N-channel parallel SPI serializer for 16-bit offset-binary DACs
//
// Purpose: holds the latest two's-complement sample per channel, converts it to
// offset binary (MSB inverted) and shifts all enabled channels out in parallel on
// a shared SCK with per-channel CS_N/SDO, then pulses LDAC_N and counts frames.
//
// Ports:
//   clk_50       in   system clock (single clock domain)
//   reset        in   synchronous active-high reset
//   ch_data      in   N_CH*DW signed samples, channel i at [i*DW +: DW]
//   ch_valid     in   per-channel strobe that updates the hold register
//   ch_enable    in   per-channel enable, captured in LOAD
//   start        in   level start; frames run back-to-back while high
//   sclk         out  shared serial clock, idle low
//   cs_n         out  per-channel chip select, active low
//   sdo          out  per-channel serial data, MSB first
//   ldac_n       out  shared load-DAC strobe, active low
//   busy         out  high in every state except IDLE
//   frame_done   out  one-cycle pulse on the final LDAC cycle
//   frame_count  out  completed frame count, wraps
module dac_multi_serializer #(
  parameter int N_CH     = 4,
  parameter int DW       = 16,
  parameter int SCK_DIV  = 2,
  parameter int LDAC_LEN = 2
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic [N_CH-1:0]    ch_valid,
  input  logic [N_CH-1:0]    ch_enable,
  input  logic               start,
  output logic               sclk,
  output logic [N_CH-1:0]    cs_n,
  output logic [N_CH-1:0]    sdo,
  output logic               ldac_n,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int PW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int LW = (LDAC_LEN > 1) ? $clog2(LDAC_LEN) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(SCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [LW-1:0] LD_LAST  = LW'(LDAC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_LDAC
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] ph_q, ph_d;        // cycle within the current SCK half-period
  logic          half_q, half_d;    // 0 = low phase, 1 = high phase
  logic [BW-1:0] bit_q, bit_d;      // bit index within the word
  logic [LW-1:0] lcnt_q, lcnt_d;    // cycle within the LDAC pulse

  logic [N_CH-1:0][DW-1:0] hold_q, hold_d;
  logic [N_CH-1:0][DW-1:0] shadow_q, shadow_d;
  logic [N_CH-1:0]         en_q, en_d;
  logic [DW-1:0]           v_c;

  logic            sclk_q, sclk_d;
  logic [N_CH-1:0] cs_n_q, cs_n_d;
  logic [N_CH-1:0] sdo_q, sdo_d;
  logic            ldac_n_q, ldac_n_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_count_q, frame_count_d;

  // Hold registers follow ch_valid in every state, frame or not.
  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_valid[i]) hold_d[i] = ch_data[i*DW +: DW];
    end
  end

  // Next-state logic and datapath.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    half_d   = half_q;
    bit_d    = bit_q;
    lcnt_d   = lcnt_q;
    shadow_d = shadow_q;
    en_d     = en_q;
    v_c      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end

      S_LOAD: begin
        // A sample strobed in this very cycle takes precedence over the hold value.
        for (int i = 0; i < N_CH; i++) begin
          v_c         = ch_valid[i] ? ch_data[i*DW +: DW] : hold_q[i];
          shadow_d[i] = {~v_c[DW-1], v_c[DW-2:0]};
        end
        en_d    = ch_enable;
        ph_d    = '0;
        half_d  = 1'b0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = S_GAP;
            end else begin
              // Advance to the next bit at the start of the low phase so SDO is
              // stable for a full half-period before the rising edge.
              bit_d = bit_q + 1'b1;
              for (int i = 0; i < N_CH; i++) begin
                shadow_d[i] = {shadow_q[i][DW-2:0], 1'b0};
              end
            end
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      S_GAP: begin
        lcnt_d  = '0;
        state_d = S_LDAC;
      end

      S_LDAC: begin
        if (lcnt_q == LD_LAST) state_d = S_IDLE;
        else                   lcnt_d  = lcnt_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from next-state values and registered, so the first
  // SHIFT cycle already presents the MSB and no input reaches an output
  // combinationally.
  always_comb begin
    sclk_d       = (state_d == S_SHIFT) && half_d;
    cs_n_d       = (state_d == S_SHIFT) ? ~en_d : '1;
    sdo_d        = '0;
    for (int i = 0; i < N_CH; i++) begin
      sdo_d[i] = (state_d == S_SHIFT) && en_d[i] && shadow_d[i][DW-1];
    end
    ldac_n_d      = (state_d != S_LDAC);
    busy_d        = (state_d != S_IDLE);
    frame_done_d  = (state_d == S_LDAC) && (lcnt_d == LD_LAST);
    frame_count_d = frame_count_q + 16'(frame_done_d);
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      half_q        <= 1'b0;
      bit_q         <= '0;
      lcnt_q        <= '0;
      hold_q        <= '0;
      shadow_q      <= '0;
      en_q          <= '0;
      sclk_q        <= 1'b0;
      cs_n_q        <= '1;
      sdo_q         <= '0;
      ldac_n_q      <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      half_q        <= half_d;
      bit_q         <= bit_d;
      lcnt_q        <= lcnt_d;
      hold_q        <= hold_d;
      shadow_q      <= shadow_d;
      en_q          <= en_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
      sdo_q         <= sdo_d;
      ldac_n_q      <= ldac_n_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sclk        = sclk_q;
  assign cs_n        = cs_n_q;
  assign sdo         = sdo_q;
  assign ldac_n      = ldac_n_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
